// File: rtl/conquest_capture_pkg.sv
// Shared types and sizing helpers for the conquest trace capture block.
// Optional define CONQUEST_CAPTURE_TIMESTAMP_EN adds a 16-bit timestamp to each word.
package conquest_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int TS_W = 16;

    // Word layout: {[timestamp], flag, samples}
    function automatic int calc_dw(input int obs_w, input int pack);
`ifdef CONQUEST_CAPTURE_TIMESTAMP_EN
        return pack * obs_w + 1 + TS_W;
`else
        return pack * obs_w + 1;
`endif
    endfunction

endpackage

// File: rtl/conquest_capture_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted if a pop frees the slot on the same edge.
module conquest_capture_fifo #(
    parameter int DW    = 9,
    parameter int DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          valid_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q, rptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign valid_o = !empty_o;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Gate the head so the output reads 0 whenever nothing is queued.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/conquest_trace_capture.sv
// Samples DUT outputs, packs PACK samples per word and streams words out through a FWFT FIFO.
// Optional define CONQUEST_CAPTURE_TIMESTAMP_EN stamps each word with its first-sample cycle count.
module conquest_trace_capture
    import conquest_capture_pkg::*;
#(
    parameter int OBS_W       = 2,
    parameter int PACK        = 4,
    parameter int DEPTH       = 8,
    parameter int MAX_SAMPLES = 64,
    localparam int DW         = calc_dw(OBS_W, PACK)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             sample_en_i,
    input  logic [OBS_W-1:0] obs_i,
    input  logic             obs_flag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             drop_o
);
    localparam int PW  = PACK * OBS_W;
    localparam int PCW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int SCW = $clog2(MAX_SAMPLES + 1);

    state_e         state_q, state_d;
    logic [PW-1:0]  pack_q, pack_d, word_nx;
    logic           flag_q, flag_d, flag_nx;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic           drop_q, drop_d;
    logic           push, push_ok;
    logic [DW-1:0]  push_data;
    logic           fifo_full, fifo_empty;

`ifdef CONQUEST_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, wts_q, wts_d, ts_word;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= '0;
        else         ts_q <= ts_q + TS_W'(1);
    end
    // A PACK=1 word completes on its first sample, so take the live count then.
    assign ts_word = (pcnt_q == '0) ? ts_q : wts_q;
`endif

    // A completed word may enter a full FIFO only if the consumer pops on the same edge.
    assign push_ok = !fifo_full || (out_valid_o && out_ready_i);

    always_comb begin
        state_d   = state_q;
        pack_d    = pack_q;
        flag_d    = flag_q;
        pcnt_d    = pcnt_q;
        scnt_d    = scnt_q;
        drop_d    = drop_q;
        push      = 1'b0;
        push_data = '0;
        word_nx   = pack_q;
        word_nx[pcnt_q*OBS_W +: OBS_W] = obs_i;
        flag_nx   = flag_q | obs_flag_i;
`ifdef CONQUEST_CAPTURE_TIMESTAMP_EN
        wts_d     = wts_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_CAPTURE;
                    pack_d  = '0;
                    flag_d  = 1'b0;
                    pcnt_d  = '0;
                    scnt_d  = '0;
                    drop_d  = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (sample_en_i) begin
                    scnt_d = scnt_q + SCW'(1);
`ifdef CONQUEST_CAPTURE_TIMESTAMP_EN
                    if (pcnt_q == '0) wts_d = ts_q;
`endif
                    if (pcnt_q == PCW'(PACK - 1)) begin
                        push = 1'b1;
`ifdef CONQUEST_CAPTURE_TIMESTAMP_EN
                        push_data = {ts_word, flag_nx, word_nx};
`else
                        push_data = {flag_nx, word_nx};
`endif
                        pack_d = '0;
                        flag_d = 1'b0;
                        pcnt_d = '0;
                        if (!push_ok) drop_d = 1'b1;
                    end else begin
                        pack_d = word_nx;
                        flag_d = flag_nx;
                        pcnt_d = pcnt_q + PCW'(1);
                    end
                end
                if ((sample_en_i && scnt_q == SCW'(MAX_SAMPLES - 1)) || stop_i)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (pcnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (push_ok) begin
                    push = 1'b1;
`ifdef CONQUEST_CAPTURE_TIMESTAMP_EN
                    push_data = {wts_q, flag_q, pack_q};
`else
                    push_data = {flag_q, pack_q};
`endif
                    pack_d  = '0;
                    flag_d  = 1'b0;
                    pcnt_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pack_q  <= '0;
            flag_q  <= 1'b0;
            pcnt_q  <= '0;
            scnt_q  <= '0;
            drop_q  <= 1'b0;
`ifdef CONQUEST_CAPTURE_TIMESTAMP_EN
            wts_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pack_q  <= pack_d;
            flag_q  <= flag_d;
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
            drop_q  <= drop_d;
`ifdef CONQUEST_CAPTURE_TIMESTAMP_EN
            wts_q   <= wts_d;
`endif
        end
    end

    conquest_capture_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (out_ready_i),
        .rdata_o (out_data_o),
        .valid_o (out_valid_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy_o = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
    assign done_o = (state_q == ST_DONE);
    assign drop_o = drop_q;

endmodule

// File: tb/tb_conquest_trace_capture.sv
// Directed bench for conquest_trace_capture: per-cycle vector table plus multi-cycle corner sequences.
module tb_conquest_trace_capture;
    localparam int OBS_W = 2;
    localparam int PACK  = 4;
    localparam int LW    = PACK * OBS_W + 1;
    localparam int DW    = conquest_capture_pkg::calc_dw(OBS_W, PACK);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, sample_en, obs_flag, out_ready;
    logic [1:0]    obs_in;
    logic          out_valid, busy, done, drop;
    logic [DW-1:0] out_data;

    int nvec  = 0;
    int nfail = 0;
    logic [LW-1:0] got_q[$];

    always #5 clk = ~clk;

    conquest_trace_capture #(.OBS_W(OBS_W), .PACK(PACK), .DEPTH(8), .MAX_SAMPLES(64)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .sample_en_i (sample_en),
        .obs_i       (obs_in),
        .obs_flag_i  (obs_flag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy),
        .done_o      (done),
        .drop_o      (drop)
    );

    typedef struct {
        logic          st, sp, en;
        logic [1:0]    obs;
        logic          fl;
        logic          ev;
        logic [LW-1:0] ed;
        logic          eb, edn;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t V(input logic st, sp, en, input logic [1:0] obs, input logic fl,
                               input logic ev, input logic [LW-1:0] ed, input logic eb, edn);
        vec_t v;
        v.st = st; v.sp = sp; v.en = en; v.obs = obs; v.fl = fl;
        v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 0; stop = 0; sample_en = 0; obs_in = 0; obs_flag = 0;
    endtask

    task automatic pulse_start();
        idle_in(); start = 1; tick(); start = 0;
    endtask

    task automatic pulse_stop();
        idle_in(); stop = 1; tick(); stop = 0;
    endtask

    task automatic sample(input logic [1:0] o, input logic f);
        sample_en = 1; obs_in = o; obs_flag = f; tick(); idle_in();
    endtask

    task automatic collect(input int n, input int bound);
        int c = 0;
        got_q.delete();
        out_ready = 1;
        while (got_q.size() < n && c < bound) begin
            if (out_valid) got_q.push_back(out_data[LW-1:0]);
            tick();
            c++;
        end
        out_ready = 0;
        chk("collect_cnt", got_q.size(), n);
    endtask

    task automatic wait_done(input int bound);
        int c = 0;
        while (!done && c < bound) begin tick(); c++; end
        chk("wait_done", done, 1);
    endtask

    task automatic run_table(input string tag);
        out_ready = 1;
        for (int i = 0; i < 13; i++) begin
            start = tbl[i].st; stop = tbl[i].sp; sample_en = tbl[i].en;
            obs_in = tbl[i].obs; obs_flag = tbl[i].fl;
            tick();
            chk($sformatf("%s_valid[%0d]", tag, i), out_valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("%s_data[%0d]", tag, i), out_data[LW-1:0], tbl[i].ed);
            chk($sformatf("%s_busy[%0d]", tag, i), busy, tbl[i].eb);
            chk($sformatf("%s_done[%0d]", tag, i), done, tbl[i].edn);
            chk($sformatf("%s_drop[%0d]", tag, i), drop, 0);
        end
        idle_in();
        out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] expq[$];
        logic [7:0]    wacc;
        logic          fa, pv, pr, stopped;
        logic [LW-1:0] pd, want;
        int            k, cyc;

        //          st sp en obs fl  ev  data     busy done
        tbl[0]  = V(1, 0, 0, 0, 0,  0, 9'h000, 1, 0);
        tbl[1]  = V(0, 0, 1, 1, 0,  0, 9'h000, 1, 0);
        tbl[2]  = V(0, 0, 1, 2, 0,  0, 9'h000, 1, 0);
        tbl[3]  = V(0, 0, 1, 3, 0,  0, 9'h000, 1, 0);
        tbl[4]  = V(0, 0, 1, 0, 0,  1, 9'h039, 1, 0);
        tbl[5]  = V(0, 0, 1, 3, 0,  0, 9'h000, 1, 0);
        tbl[6]  = V(0, 0, 1, 3, 0,  0, 9'h000, 1, 0);
        tbl[7]  = V(0, 0, 1, 1, 0,  0, 9'h000, 1, 0);
        tbl[8]  = V(0, 0, 1, 0, 0,  1, 9'h01F, 1, 0);
        tbl[9]  = V(0, 1, 0, 0, 0,  0, 9'h000, 1, 0);
        tbl[10] = V(0, 0, 0, 0, 0,  0, 9'h000, 1, 0);
        tbl[11] = V(0, 0, 0, 0, 0,  0, 9'h000, 0, 1);
        tbl[12] = V(0, 0, 0, 0, 0,  0, 9'h000, 0, 1);

        rst_n = 0; out_ready = 0; idle_in();
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data[LW-1:0], 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_drop", drop, 0);
        rst_n = 1;
        tick();

        // basic packing
        run_table("basic");

        // flag ORing and zero-padded partial flush
        pulse_start();
        chk("flag_done_clr", done, 0);
        sample(1, 0); sample(1, 1); sample(1, 0); sample(1, 0);
        sample(2, 0); sample(3, 0);
        pulse_stop();
        tick();
        chk("flag_busy", busy, 1);
        chk("flag_valid", out_valid, 1);
        collect(2, 20);
        if (got_q.size() == 2) begin
            chk("flag_w0", got_q[0], 9'h155);
            chk("flag_w1", got_q[1], 9'h00E);
        end
        wait_done(10);

        // full FIFO: 16 words, first 8 kept, rest dropped
        pulse_start();
        for (int s = 0; s < 64; s++) begin
            sample_en = 1; obs_in = 2'((s >> 2) & 3); obs_flag = 0; tick();
        end
        idle_in();
        tick(); tick(); tick(); tick(); tick();
        chk("full_drop", drop, 1);
        chk("full_busy", busy, 1);
        chk("full_hold_done", done, 0);
        chk("full_valid", out_valid, 1);
        collect(8, 40);
        for (int w = 0; w < 8 && w < got_q.size(); w++) begin
            want = LW'((w & 3) * 8'h55);
            chk($sformatf("full_w%0d", w), got_q[w], want);
        end
        tick();
        chk("full_empty", out_valid, 0);
        wait_done(10);
        chk("full_drop_kept", drop, 1);

        // simultaneous push and pop while full
        pulse_start();
        chk("pp_drop_clr", drop, 0);
        for (int s = 0; s < 36; s++) begin
            out_ready = (s == 35);
            sample_en = 1; obs_in = 2'((s >> 2) & 3); obs_flag = 0; tick();
        end
        idle_in(); out_ready = 0;
        chk("pp_drop", drop, 0);
        chk("pp_head", out_data[LW-1:0], 9'h055);
        pulse_stop();
        collect(8, 40);
        for (int w = 0; w < 8 && w < got_q.size(); w++) begin
            want = LW'(((w + 1) & 3) * 8'h55);
            chk($sformatf("pp_w%0d", w), got_q[w], want);
        end
        wait_done(10);
        chk("pp_drop_end", drop, 0);

        // random backpressure
        pulse_start();
        k = 0; cyc = 0; stopped = 0; wacc = '0; fa = 0;
        while (!done && cyc < 600) begin
            out_ready = 1'($urandom_range(0, 1));
            sample_en = (k < 32);
            obs_in = 2'($urandom_range(0, 3));
            obs_flag = ($urandom_range(0, 7) == 0);
            stop = 0;
            if (k == 32 && !stopped) begin stop = 1; stopped = 1; end
            if (sample_en) begin
                wacc[(k % 4) * 2 +: 2] = obs_in;
                fa = fa | obs_flag;
                if (k % 4 == 3) begin
                    expq.push_back({fa, wacc});
                    wacc = '0; fa = 0;
                end
                k++;
            end
            pv = out_valid; pr = out_ready; pd = out_data[LW-1:0];
            tick();
            if (pv && pr) begin
                if (expq.size() == 0) chk("bp_extra", 1, 0);
                else chk("bp_order", pd, expq.pop_front());
            end
            if (pv && !pr) begin
                chk("bp_hold_v", out_valid, 1);
                chk("bp_hold_d", out_data[LW-1:0], pd);
            end
            cyc++;
        end
        idle_in(); out_ready = 0;
        chk("bp_done", done, 1);
        chk("bp_left", expq.size(), 0);

        // asynchronous reset mid-capture
        pulse_start();
        for (int s = 0; s < 5; s++) sample(3, 0);
        chk("ar_pre_valid", out_valid, 1);
        #3 rst_n = 0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data[LW-1:0], 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_drop", drop, 0);
        #10 rst_n = 1;
        tick();
        run_table("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/conquest_trace_capture.md
Name: conquest_trace_capture

Overview:
- Response-side counterpart of the stimulus program counter: samples DUT output bits (e.g. outp/overflw of b01) every enabled cycle and packs them into words.
- Buffers the words in a small FIFO and drains them over a valid/ready stream to the trace dump or checker.
- Sits between the DUT outputs and the result reader in the conquest harness, so captured traces replace ad-hoc $strobe output.

Parameters:
- OBS_W, 2, number of DUT output bits sampled per cycle.
- PACK, 4, samples per packed word (>=1).
- DEPTH, 8, FIFO depth in words (power of 2, >=2).
- MAX_SAMPLES, 64, samples per capture run before automatic stop (>=1).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a capture run from IDLE or DONE.
- stop  in  1  one-cycle pulse; ends capture early (CAPTURE only).
- sample_en  in  1  a sample is taken on this edge when high in CAPTURE.
- obs_in  in  OBS_W  DUT output bits to sample.
- obs_flag  in  1  marker bit (driven from __obs); ORed into the word flag.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word when high with out_valid.
- out_data  out  DW  head word, DW = PACK*OBS_W+1 (+16 with timestamp).
- busy  out  1  state is CAPTURE, FLUSH or DRAIN.
- done  out  1  high in DONE until next start.
- drop  out  1  sticky: at least one word was lost to a full FIFO this run.

Behaviour:
- Reset (reset=0, async): state IDLE; FIFO empty; pack count, sample count and drop all 0; out_valid/busy/done/drop = 0; out_data = 0.
- States: IDLE, CAPTURE, FLUSH, DRAIN, DONE.
- IDLE/DONE + start -> CAPTURE. Clears sample count, pack register, drop and done. FIFO contents are not cleared.
- CAPTURE, each edge with sample_en=1:
  - Sample k of a word goes to bits [k*OBS_W +: OBS_W]; the first sample is in the LSBs.
  - Bit PACK*OBS_W is the word flag = OR of obs_flag over the word's samples.
  - The sample count increments.
- Word completion: the edge taking sample PACK pushes the word on that same edge. It appears at out_valid one cycle later if the FIFO was empty.
- Full FIFO:
  - A push while full is dropped and drop sets.
  - Exception: a pop on the same edge (out_valid && out_ready) frees the slot, and the push is accepted.
- CAPTURE -> FLUSH when the sample count reaches MAX_SAMPLES (on that edge) or on stop. If both occur, MAX_SAMPLES takes priority; the result is identical.
- FLUSH:
  - If a partial word exists, wait until the FIFO is not full, then push it zero-padded in the unused sample slots. Partial words are never dropped.
  - Then go to DRAIN; with no partial word, go to DRAIN on the next edge.
- DRAIN -> DONE when the FIFO is empty. done asserts in DONE.
- Ignored inputs: start in CAPTURE/FLUSH/DRAIN; stop outside CAPTURE; sample_en outside CAPTURE.
- Output stream: first-word-fall-through. out_data is stable while out_valid && !out_ready, and out_valid never deasserts without a pop.
- Counters: the sample count is sized clog2(MAX_SAMPLES+1); FIFO pointers wrap modulo DEPTH with an extra wrap bit for the full/empty distinction.
- Reset mid-run aborts immediately to the reset values; no partial flush.

Optional Feature:
- Macro: CONQUEST_CAPTURE_TIMESTAMP_EN.
- Defined: a free-running 16-bit cycle counter is added. It resets to 0 and wraps at 0xFFFF; start does not clear it. Its value at the edge of each word's first sample is placed in out_data[DW-1 -: 16], and DW grows by 16.
- Undefined: no counter; DW = PACK*OBS_W+1.

Decomposition:
- Package conquest_capture_pkg: the state enum, the DW computation function, and the timestamp width constant (16).
- Sub-module conquest_capture_fifo: parameterised DW/DEPTH FWFT FIFO with simultaneous push/pop-when-full support and full/empty flags.
- All packing and FSM logic stays in the top.

Test Plan:
- Basic pack: start; 8 samples obs_in = 1,2,3,0,3,3,1,0 with obs_flag low; out_ready=1 → two words 9'h039 then 9'h01F; done after DRAIN.
- Flag and partial flush: obs_flag high on sample 2 only; stop after 6 samples → word0 flag=1; word1 holds 2 samples, upper slots 0, flag=0.
- Full FIFO: out_ready=0, MAX_SAMPLES=64 → 8 words stored, remaining 8 dropped, drop=1. DRAIN holds until out_ready=1; exactly 8 words are read.
- Push/pop when full: FIFO full, out_ready=1 on the completing edge → push accepted, drop stays 0.
- Backpressure: toggle out_ready randomly → out_data stable while stalled; words in order, none duplicated.
- Reset mid-capture: assert reset low after 3 samples → all outputs 0 asynchronously; a new run after release behaves like the first test.
